// File: rtl/fpu_sqrt_iter.sv
`default_nettype none
// ============================================================================
// Module   : fpu_sqrt_iter
// Brief    : Iterative IEEE-754 square root, one root bit per cycle, RNE,
//            start/cmd_end/busy handshake. FPU_SQRT_DENORM_EN normalises
//            denormal inputs; otherwise they are flushed to a signed zero.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_sqrt_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   a_operand,
    output logic [EXP_W+MAN_W:0]   ieee_packet_out,
    output logic                   cmd_end,
    output logic                   busy,
    output logic                   invalid,
    output logic                   inexact
);
    localparam int c_W  = 1 + EXP_W + MAN_W;
    localparam int c_EW = 16;
    localparam int c_CW = 6;
    localparam int c_RW = MAN_W + 4;
    localparam int c_QW = MAN_W + 2;
    localparam int c_DW = 2 * MAN_W + 4;
    localparam logic signed [c_EW-1:0] c_BIAS = c_EW'((1 << (EXP_W - 1)) - 1);
    localparam logic [c_CW-1:0] c_ITER_LAST = c_CW'(MAN_W + 1);
    localparam logic [c_W-1:0] c_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_NORM   = 3'd2,
        S_ITER   = 3'd3,
        S_ROUND  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [c_W-1:0]  r_op;
    logic [c_DW-1:0] r_rad;
    logic [c_RW-1:0] r_rem;
    logic [c_QW-1:0] r_q;
    logic [c_CW-1:0] r_cnt;
    logic [EXP_W-1:0] r_exp;
    logic            r_special;
    logic [c_W-1:0]  r_spec_res;
    logic            r_spec_inv;

    // operand fields and classification
    logic             w_sign;
    logic [EXP_W-1:0] w_exp_f;
    logic [MAN_W-1:0] w_frac;
    logic             w_exp_max;
    logic             w_exp_zero;
    logic             w_frac_zero;
    logic             w_special;
    logic [c_W-1:0]   w_spec_res;
    logic             w_spec_inv;

    assign w_sign      = r_op[c_W-1];
    assign w_exp_f     = r_op[c_W-2:MAN_W];
    assign w_frac      = r_op[MAN_W-1:0];
    assign w_exp_max   = &w_exp_f;
    assign w_exp_zero  = ~|w_exp_f;
    assign w_frac_zero = ~|w_frac;

    always_comb begin
        w_special  = 1'b1;
        w_spec_res = c_QNAN;
        w_spec_inv = 1'b0;
        if (w_exp_max && !w_frac_zero) begin
            w_spec_inv = ~w_frac[MAN_W-1];
        end else if (w_exp_zero && w_frac_zero) begin
            w_spec_res = r_op;
`ifndef FPU_SQRT_DENORM_EN
        end else if (w_exp_zero) begin
            w_spec_res = {w_sign, {(c_W-1){1'b0}}};
`endif
        end else if (w_sign) begin
            w_spec_inv = 1'b1;
        end else if (w_exp_max) begin
            w_spec_res = r_op;
        end else begin
            w_special = 1'b0;
        end
    end

`ifdef FPU_SQRT_DENORM_EN
    logic [c_CW-1:0] r_shift;
    logic [c_CW-1:0] w_lzc;

    // shift that moves the leading one of a denormal fraction into the hidden bit
    always_comb begin
        w_lzc = '0;
        for (int i = 0; i < MAN_W; i++) begin
            if (w_frac[i]) w_lzc = c_CW'(MAN_W - i);
        end
    end
`endif

    // iteration setup: unbiased exponent, significand and result exponent
    logic [MAN_W-1:0]        w_ld_frac;
    logic signed [c_EW-1:0]  w_ld_e;
    logic [c_QW-1:0]         w_ld_s;
    logic [EXP_W-1:0]        w_res_exp;

    always_comb begin
        w_ld_frac = w_frac;
        w_ld_e    = $signed(c_EW'(w_exp_f)) - c_BIAS;
`ifdef FPU_SQRT_DENORM_EN
        if (r_state == S_NORM) begin
            w_ld_frac = w_frac << r_shift;
            w_ld_e    = $signed(c_EW'(1)) - c_BIAS - $signed(c_EW'(r_shift));
        end
`endif
    end

    assign w_ld_s    = w_ld_e[0] ? {1'b1, w_ld_frac, 1'b0} : {2'b01, w_ld_frac};
    assign w_res_exp = EXP_W'((w_ld_e >>> 1) + c_BIAS);

    // restoring root step: trial subtract (4q+1) from the shifted remainder
    logic [c_RW+1:0] w_cur;
    logic [c_RW-1:0] w_sub;
    logic [c_RW-1:0] w_diff;
    logic            w_ge;

    assign w_cur  = {r_rem, r_rad[c_DW-1 -: 2]};
    assign w_sub  = {r_q, 2'b01};
    assign w_ge   = (w_cur >= {2'b00, w_sub});
    assign w_diff = w_cur[c_RW-1:0] - w_sub;

    // round to nearest-even
    logic [MAN_W:0]   w_m;
    logic             w_guard;
    logic             w_sticky;
    logic             w_up;
    logic             w_carry;
    logic [MAN_W-1:0] w_frac_rnd;
    logic [EXP_W-1:0] w_exp_rnd;

    assign w_m        = r_q[c_QW-1:1];
    assign w_guard    = r_q[0];
    assign w_sticky   = |r_rem;
    assign w_up       = w_guard & (w_sticky | w_m[0]);
    assign w_carry    = w_up & (&w_m);
    assign w_frac_rnd = w_m[MAN_W-1:0] + MAN_W'(w_up);
    assign w_exp_rnd  = r_exp + EXP_W'(w_carry);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // specials pass through ROUND so every result loads the outputs from one place
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_UNPACK;
            S_UNPACK: begin
                if (w_special) begin
                    w_next = S_ROUND;
`ifdef FPU_SQRT_DENORM_EN
                end else if (w_exp_zero) begin
                    w_next = S_NORM;
`endif
                end else begin
                    w_next = S_ITER;
                end
            end
            S_NORM:   w_next = S_ITER;
            S_ITER:   if (r_cnt == '0) w_next = S_ROUND;
            S_ROUND:  w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_op            <= '0;
            r_rad           <= '0;
            r_rem           <= '0;
            r_q             <= '0;
            r_cnt           <= '0;
            r_exp           <= '0;
            r_special       <= 1'b0;
            r_spec_res      <= '0;
            r_spec_inv      <= 1'b0;
`ifdef FPU_SQRT_DENORM_EN
            r_shift         <= '0;
`endif
            ieee_packet_out <= '0;
            cmd_end         <= 1'b0;
            busy            <= 1'b0;
            invalid         <= 1'b0;
            inexact         <= 1'b0;
        end else begin
            cmd_end <= (w_next == S_DONE);
            busy    <= (w_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (start) r_op <= a_operand;
                end
                S_UNPACK, S_NORM: begin
                    r_special  <= w_special;
                    r_spec_res <= w_spec_res;
                    r_spec_inv <= w_spec_inv;
                    r_rad      <= {w_ld_s, {c_QW{1'b0}}};
                    r_rem      <= '0;
                    r_q        <= '0;
                    r_cnt      <= c_ITER_LAST;
                    r_exp      <= w_res_exp;
`ifdef FPU_SQRT_DENORM_EN
                    if (r_state == S_UNPACK) r_shift <= w_lzc;
`endif
                end
                S_ITER: begin
                    r_rad <= {r_rad[c_DW-3:0], 2'b00};
                    r_rem <= w_ge ? w_diff : w_cur[c_RW-1:0];
                    r_q   <= {r_q[c_QW-2:0], w_ge};
                    r_cnt <= r_cnt - 1'b1;
                end
                S_ROUND: begin
                    if (r_special) begin
                        ieee_packet_out <= r_spec_res;
                        invalid         <= r_spec_inv;
                        inexact         <= 1'b0;
                    end else begin
                        ieee_packet_out <= {w_sign, w_exp_rnd, w_frac_rnd};
                        invalid         <= 1'b0;
                        inexact         <= w_guard | w_sticky;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_sqrt_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_sqrt_iter
// Brief    : Directed self-checking bench for fpu_sqrt_iter (single and half).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_sqrt_iter;
    logic        clk  = 1'b0;
    logic        arst = 1'b1;

    logic        start_s = 1'b0;
    logic [31:0] op_s    = '0;
    logic [31:0] res_s;
    logic        end_s, busy_s, inv_s, inx_s;

    logic        start_h = 1'b0;
    logic [15:0] op_h    = '0;
    logic [15:0] res_h;
    logic        end_h, busy_h, inv_h, inx_h;

    bit          sel_h = 1'b0;
    int          checks = 0;
    int          errors = 0;

    wire [31:0] res_m  = sel_h ? {16'h0, res_h} : res_s;
    wire        end_m  = sel_h ? end_h  : end_s;
    wire        busy_m = sel_h ? busy_h : busy_s;
    wire        inv_m  = sel_h ? inv_h  : inv_s;
    wire        inx_m  = sel_h ? inx_h  : inx_s;

    fpu_sqrt_iter #(.EXP_W(8), .MAN_W(23)) dut_s (
        .clk(clk), .arst(arst), .start(start_s), .a_operand(op_s),
        .ieee_packet_out(res_s), .cmd_end(end_s), .busy(busy_s),
        .invalid(inv_s), .inexact(inx_s)
    );

    fpu_sqrt_iter #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .arst(arst), .start(start_h), .a_operand(op_h),
        .ieee_packet_out(res_h), .cmd_end(end_h), .busy(busy_h),
        .invalid(inv_h), .inexact(inx_h)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic run(input bit half, input logic [31:0] op, input logic [31:0] want_res,
                       input bit want_inv, input bit want_inx, input int want_lat,
                       input string tag);
        int lat;
        @(negedge clk);
        sel_h = half;
        if (half) begin op_h = op[15:0]; start_h = 1'b1; end
        else      begin op_s = op;       start_s = 1'b1; end
        @(posedge clk); #1;
        start_s = 1'b0;
        start_h = 1'b0;
        lat = 0;
        while (!end_m && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, want_lat);
        check({tag, "_res"}, res_m, want_res);
        check({tag, "_inv"}, {31'b0, inv_m}, {31'b0, want_inv});
        check({tag, "_inx"}, {31'b0, inx_m}, {31'b0, want_inx});
        check({tag, "_busy"}, {31'b0, busy_m}, 32'd1);
        @(posedge clk); #1;
        check({tag, "_idle"}, {30'b0, busy_m, end_m}, 32'd0);
        check({tag, "_hold"}, res_m, want_res);
    endtask

    initial begin
        int n_end, n_idle, first, second, n;
        logic [31:0] res_at_end;

        repeat (2) @(posedge clk);
        #1;
        check("rst_res",  res_s, 32'h0);
        check("rst_flags", {27'b0, end_s, busy_s, inv_s, inx_s, 1'b0}, 32'h0);
        check("rst_res_h", {16'h0, res_h}, 32'h0);
        @(negedge clk);
        arst = 1'b0;

        run(0, 32'h40800000, 32'h40000000, 0, 0, 27, "sqrt4");
        run(0, 32'h3E800000, 32'h3F000000, 0, 0, 27, "sqrt025");
        run(0, 32'h40000000, 32'h3FB504F3, 0, 1, 27, "sqrt2");
        run(0, 32'hBF800000, 32'h7FC00000, 1, 0, 2,  "neg1");
        run(0, 32'h7FA00000, 32'h7FC00000, 1, 0, 2,  "snan");
        run(0, 32'h7FC00000, 32'h7FC00000, 0, 0, 2,  "qnan");
        run(0, 32'h7F800000, 32'h7F800000, 0, 0, 2,  "pinf");
        run(0, 32'h80000000, 32'h80000000, 0, 0, 2,  "nzero");
        run(0, 32'hFF800000, 32'h7FC00000, 1, 0, 2,  "ninf");
`ifdef FPU_SQRT_DENORM_EN
        run(0, 32'h00000001, 32'h1A3504F3, 0, 1, 28, "denorm");
`else
        run(0, 32'h00000001, 32'h00000000, 0, 0, 2,  "denorm");
`endif
        run(1, 32'h00004400, 32'h00004000, 0, 0, 14, "h_sqrt4");
        run(1, 32'h00004000, 32'h00003DA8, 0, 1, 14, "h_sqrt2");

        // start held high: two back-to-back operations
        @(negedge clk);
        sel_h = 1'b0;
        op_s = 32'h40800000;
        start_s = 1'b1;
        @(posedge clk); #1;
        n_end = 0; n_idle = 0; first = 0; second = 0;
        for (int i = 1; i <= 56; i++) begin
            @(posedge clk); #1;
            if (end_s) begin
                n_end++;
                if (n_end == 1) first = i; else second = i;
            end
            if (!busy_s) n_idle++;
        end
        start_s = 1'b0;
        check("b2b_ends",   n_end,  2);
        check("b2b_idle",   n_idle, 1);
        check("b2b_first",  first,  27);
        check("b2b_second", second, 56);
        check("b2b_res",    res_s,  32'h40000000);
        repeat (2) @(posedge clk);
        #1;
        check("b2b_quiet", {31'b0, busy_s}, 32'd0);

        // start pulsed mid-operation must be ignored
        @(negedge clk);
        op_s = 32'h40800000;
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        n_end = 0; first = 0; res_at_end = '0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 5) begin op_s = 32'h40000000; start_s = 1'b1; end
            if (i == 6) start_s = 1'b0;
            if (end_s) begin
                n_end++;
                first = i;
                res_at_end = res_s;
            end
        end
        check("ign_ends",  n_end, 1);
        check("ign_lat",   first, 27);
        check("ign_res",   res_at_end, 32'h40000000);
        check("ign_quiet", {31'b0, busy_s}, 32'd0);

        // asynchronous abort during iteration
        @(negedge clk);
        op_s = 32'h40000000;
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        arst = 1'b1;
        #1;
        check("abort_res",   res_s, 32'h0);
        check("abort_flags", {27'b0, end_s, busy_s, inv_s, inx_s, 1'b0}, 32'h0);
        repeat (2) @(negedge clk);
        arst = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (end_s || busy_s) n++;
        end
        check("abort_no_end", n, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
